// File: rtl/cs_window.sv
// Sliding-window accumulator: keeps the last DEPTH samples and their sum, and outputs
// (sum + DEPTH*appr) >> SHIFT. Define CS_ROUND_EN to round half-up with saturation instead of truncating.
module cs_window #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SHIFT = 3,
  localparam int SW   = DW + $clog2(DEPTH),
  localparam int YW   = SW + 1 - SHIFT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          x_valid,
  input  logic [DW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          y_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = SW + 1;

  logic [DEPTH-1:0][DW-1:0] r_win;
  logic [SW-1:0]            r_sum;
  logic [CW-1:0]            r_cnt;
  logic                     r_acc;

  logic [DW-1:0]            w_avg;
  logic [DW-1:0]            w_appr;
  logic [TW-1:0]            w_total;
  logic [YW-1:0]            w_y;
  logic                     w_full;

  assign w_avg   = DW'(r_sum / SW'(DEPTH));
  assign w_total = TW'(r_sum) + TW'(DEPTH) * TW'(w_appr);
  assign w_full  = (r_cnt == CW'(DEPTH));

  // The window minimum never exceeds the average, so at least one sample qualifies.
  always_comb begin
    w_appr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((r_win[i] <= w_avg) && (r_win[i] > w_appr)) begin
        w_appr = r_win[i];
      end
    end
  end

`ifdef CS_ROUND_EN
  logic [TW:0]   w_rnd;
  logic [YW:0]   w_rsh;

  assign w_rnd = {1'b0, w_total} + (TW + 1)'(2 ** (SHIFT - 1));
  assign w_rsh = (YW + 1)'(w_rnd >> SHIFT);
  assign w_y   = w_rsh[YW] ? '1 : w_rsh[YW-1:0];
`else
  assign w_y = YW'(w_total >> SHIFT);
`endif

  // r_acc marks an accept at the previous edge; the result is taken one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= r_acc && w_full;
      if (r_acc && w_full) begin
        Y <= w_y;
      end

      if (clr) begin
        r_win <= '0;
        r_sum <= '0;
        r_cnt <= '0;
        r_acc <= 1'b0;
      end else if (x_valid) begin
        r_win <= {r_win[DEPTH-2:0], X};
        r_sum <= r_sum - SW'(r_win[DEPTH-1]) + SW'(X);
        if (!w_full) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_acc <= 1'b1;
      end else begin
        r_acc <= 1'b0;
      end
    end
  end

endmodule
